// File: rtl/aqed_multi_dup.sv
// ============================================================================
// Module   : aqed_multi_dup
// Brief    : A-QED self-consistency monitor. Re-issues one original write as
//            NUM_DUP duplicates and compares the read-side copies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aqed_multi_dup #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int NUM_DUP    = 2,
    parameter int BOUND      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  exec_dup,
    input  logic                  wen_in,
    input  logic                  ren_in,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  valid_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  qed_done,
    output logic                  qed_check,
    output logic                  qed_timeout,
    output logic [NUM_DUP-1:0]    dup_match
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_DUP  = 3'd1;
    localparam logic [2:0] c_WAIT = 3'd2;
    localparam logic [2:0] c_DONE = 3'd3;
    localparam logic [2:0] c_FAIL = 3'd4;

    localparam int              c_KW     = 3;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(NUM_DUP - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nx;
    logic [CNT_WIDTH-1:0]  r_in_count;
    logic [CNT_WIDTH-1:0]  r_out_count;
    logic [CNT_WIDTH-1:0]  r_orig_idx;
    logic [CNT_WIDTH-1:0]  r_dup_idx [NUM_DUP];
    logic [DATA_WIDTH-1:0] r_orig_in;
    logic [DATA_WIDTH-1:0] r_orig_out;
    logic [DATA_WIDTH-1:0] r_dup_out [NUM_DUP];
    logic                  r_orig_vld;
    logic                  r_got_orig;
    logic [NUM_DUP-1:0]    r_dup_vld;
    logic [NUM_DUP-1:0]    r_got;
    logic [c_KW-1:0]       r_k;
    logic [31:0]           r_timer;
    logic                  r_timeout;

    logic                  w_acc_in;
    logic                  w_acc_out;
    logic                  w_live;
    logic                  w_flush;
    logic                  w_issue_orig;
    logic                  w_issue_dup;
    logic                  w_cap_orig;
    logic [NUM_DUP-1:0]    w_cap_dup;
    logic                  w_found;
    logic                  w_complete;
    logic                  w_bound_hit;

    assign w_acc_in     = clk_en & wen_in & ~flush & (~full | ren_in);
    assign w_acc_out    = clk_en & ~empty & valid_out;
    assign w_live       = (r_state == c_IDLE) || (r_state == c_DUP) || (r_state == c_WAIT);
    assign w_flush      = clk_en & flush & w_live;
    assign w_issue_orig = (r_state == c_IDLE) & w_acc_in & exec_dup;
    assign w_issue_dup  = (r_state == c_DUP) & w_acc_in & exec_dup;

    assign data_out = w_issue_dup ? r_orig_in : data_in;

    // The original has priority; otherwise the lowest-numbered matching duplicate.
    always_comb begin
        w_cap_orig = 1'b0;
        w_cap_dup  = '0;
        w_found    = 1'b0;
        if (w_acc_out && w_live && !w_flush) begin
            if (r_orig_vld && (r_out_count == r_orig_idx)) begin
                w_cap_orig = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DUP; i++) begin
                    if (!w_found && r_dup_vld[i] && (r_out_count == r_dup_idx[i])) begin
                        w_cap_dup[i] = 1'b1;
                        w_found      = 1'b1;
                    end
                end
            end
        end
    end

    assign w_complete  = (r_got_orig | w_cap_orig) & (&(r_got | w_cap_dup));
    assign w_bound_hit = (BOUND != 0) && (r_timer == 32'(BOUND)) && !w_complete;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_IDLE: if (w_issue_orig) w_state_nx = c_DUP;
            c_DUP:  if (w_issue_dup && (r_k == c_K_LAST)) w_state_nx = c_WAIT;
            c_WAIT: begin
                if (w_complete)       w_state_nx = c_DONE;
                else if (w_bound_hit) w_state_nx = c_FAIL;
            end
            default: w_state_nx = r_state;
        endcase
        if (w_flush) w_state_nx = c_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_in_count  <= '0;
            r_out_count <= '0;
            r_orig_idx  <= '0;
            r_orig_in   <= '0;
            r_orig_out  <= '0;
            r_orig_vld  <= 1'b0;
            r_got_orig  <= 1'b0;
            r_dup_vld   <= '0;
            r_got       <= '0;
            r_k         <= '0;
            r_timer     <= '0;
            r_timeout   <= 1'b0;
            for (int i = 0; i < NUM_DUP; i++) begin
                r_dup_idx[i] <= '0;
                r_dup_out[i] <= '0;
            end
        end else if (clk_en) begin
            r_state <= w_state_nx;
            r_timer <= ((r_state == c_WAIT) && !w_flush) ? r_timer + 32'd1 : 32'd0;
            if (w_flush) begin
                r_in_count  <= '0;
                r_out_count <= '0;
                r_orig_vld  <= 1'b0;
                r_got_orig  <= 1'b0;
                r_dup_vld   <= '0;
                r_got       <= '0;
                r_k         <= '0;
            end else begin
                if (w_acc_in)  r_in_count  <= r_in_count + 1'b1;
                if (w_acc_out) r_out_count <= r_out_count + 1'b1;
                if (w_issue_orig) begin
                    r_orig_in  <= data_in;
                    r_orig_idx <= r_in_count;
                    r_orig_vld <= 1'b1;
                    r_k        <= '0;
                end
                if (w_issue_dup) r_k <= r_k + 1'b1;
                for (int i = 0; i < NUM_DUP; i++) begin
                    if (w_issue_dup && (r_k == c_KW'(i))) begin
                        r_dup_idx[i] <= r_in_count;
                        r_dup_vld[i] <= 1'b1;
                    end
                    if (w_cap_dup[i]) begin
                        r_dup_out[i] <= data_out_in;
                        r_got[i]     <= 1'b1;
                    end
                end
                if (w_cap_orig) begin
                    r_orig_out <= data_out_in;
                    r_got_orig <= 1'b1;
                end
                if ((r_state == c_WAIT) && w_bound_hit) r_timeout <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_DUP; g++) begin : g_match
            assign dup_match[g] = (r_dup_out[g] == r_orig_out);
        end
    endgenerate

    assign qed_done    = (r_state == c_DONE) || (r_state == c_FAIL);
    assign qed_timeout = r_timeout;
    assign qed_check   = ~qed_done | ((&dup_match) & ~r_timeout);

endmodule

`default_nettype wire

// File: tb/tb_aqed_multi_dup.sv
// ============================================================================
// Module   : tb_aqed_multi_dup
// Brief    : Self-checking bench for aqed_multi_dup with a FIFO core model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aqed_multi_dup;

    localparam int DW    = 16;
    localparam int ND    = 2;
    localparam int BND   = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clk_en = 1'b0, flush = 1'b0, exec_dup = 1'b0;
    logic          wen_in = 1'b0, ren_in = 1'b0, full = 1'b0, empty = 1'b1, valid_out = 1'b0;
    logic [DW-1:0] data_in = '0, data_out_in = '0, data_out;
    logic          qed_done, qed_check, qed_timeout;
    logic [ND-1:0] dup_match;

    always #5 clk = ~clk;

    aqed_multi_dup #(.DATA_WIDTH(DW), .CNT_WIDTH(32), .NUM_DUP(ND), .BOUND(BND)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .exec_dup(exec_dup),
        .wen_in(wen_in), .ren_in(ren_in), .full(full), .empty(empty), .valid_out(valid_out),
        .data_in(data_in), .data_out_in(data_out_in), .data_out(data_out),
        .qed_done(qed_done), .qed_check(qed_check), .qed_timeout(qed_timeout),
        .dup_match(dup_match)
    );

    int checks = 0, errors = 0;

    // Core: a plain FIFO, with an optional single corrupted read.
    logic [DW-1:0] q[$];
    int            rd_cnt = 0;
    int            corrupt_at = -1;
    bit            force_full = 1'b0;
    logic [DW-1:0] last_dout;

    // Reference: run phase, index bookkeeping, captured words.
    int            m_st;
    int unsigned   m_in, m_out, m_oidx, m_timer;
    logic [DW-1:0] m_oin, m_oout;
    logic [DW-1:0] m_dout [ND];
    int unsigned   m_didx[$];
    bit            m_ovld, m_gorig, m_tout;
    bit            m_got [ND];

    typedef struct {
        bit            we, re, ex;
        logic [DW-1:0] din, exp_dout;
        bit            exp_done, exp_check;
        logic [ND-1:0] exp_match;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_flush();
        m_st = 0; m_in = 0; m_out = 0; m_timer = 0;
        m_didx.delete(); m_ovld = 0; m_gorig = 0;
        for (int k = 0; k < ND; k++) m_got[k] = 0;
    endfunction

    function automatic void model_reset();
        model_flush();
        m_oin = '0; m_oout = '0; m_oidx = 0; m_tout = 0;
        for (int k = 0; k < ND; k++) m_dout[k] = '0;
    endfunction

    function automatic logic [ND-1:0] exp_match();
        logic [ND-1:0] r;
        for (int k = 0; k < ND; k++) r[k] = (m_dout[k] == m_oout);
        return r;
    endfunction

    task automatic cyc(input bit ce, input bit we, input bit re, input bit ex,
                       input bit fl, input logic [DW-1:0] din);
        bit            ai, ao, idp, live, comp, hit;
        logic [DW-1:0] dsnap;
        clk_en = ce; wen_in = we; ren_in = re; exec_dup = ex; flush = fl; data_in = din;
        empty       = (q.size() == 0);
        full        = force_full || (q.size() >= DEPTH);
        valid_out   = re && !empty;
        data_out_in = empty ? '0 : ((rd_cnt == corrupt_at) ? (q[0] ^ 16'h0001) : q[0]);
        #1;
        ai  = ce && we && !fl && (!full || re);
        ao  = ce && !empty && valid_out;
        idp = (m_st == 1) && ai && ex;
        chk("data_out", data_out, idp ? m_oin : din);
        dsnap     = data_out;
        last_dout = data_out;
        if (ce) begin
            live = (m_st < 3);
            if (fl && live) model_flush();
            else begin
                if (ao && live) begin
                    if (m_ovld && m_out == m_oidx) begin
                        m_oout = data_out_in; m_gorig = 1;
                    end else begin
                        hit = 0;
                        for (int k = 0; k < m_didx.size(); k++)
                            if (!hit && m_out == m_didx[k]) begin
                                m_dout[k] = data_out_in; m_got[k] = 1; hit = 1;
                            end
                    end
                end
                comp = m_gorig;
                for (int k = 0; k < ND; k++) comp = comp && m_got[k];
                case (m_st)
                    0: if (ai && ex) begin
                        m_oin = din; m_oidx = m_in; m_ovld = 1; m_st = 1;
                    end
                    1: if (idp) begin
                        m_didx.push_back(m_in);
                        if (m_didx.size() == ND) begin m_st = 2; m_timer = 0; end
                    end
                    2: if (comp) m_st = 3;
                       else if (BND != 0 && m_timer == BND) begin m_st = 4; m_tout = 1; end
                       else m_timer++;
                    default: ;
                endcase
                if (ai) m_in++;
                if (ao) m_out++;
            end
        end
        @(posedge clk);
        if (ce) begin
            if (fl) begin q.delete(); rd_cnt = 0; end
            else begin
                if (ao) begin void'(q.pop_front()); rd_cnt++; end
                if (ai) q.push_back(dsnap);
            end
        end
        @(negedge clk);
        chk("qed_done", qed_done, m_st >= 3);
        chk("qed_timeout", qed_timeout, m_tout);
        chk("dup_match", dup_match, exp_match());
        chk("qed_check", qed_check, (m_st < 3) || ((&exp_match()) && !m_tout));
    endtask

    // Reset is asserted between edges so its effect is seen before any clock.
    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rst_done", qed_done, 1'b0);
        chk("rst_check", qed_check, 1'b1);
        chk("rst_timeout", qed_timeout, 1'b0);
        chk("rst_match", dup_match, {ND{1'b1}});
        model_reset(); q.delete(); rd_cnt = 0; corrupt_at = -1; force_full = 0;
        clk_en = 0; wen_in = 0; ren_in = 0; exec_dup = 0; flush = 0; data_in = '0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 4; i++) begin
            cyc(1, tbl[i].we, tbl[i].re, tbl[i].ex, 0, tbl[i].din);
            chk({tag, "_dout"}, last_dout, tbl[i].exp_dout);
            chk({tag, "_done"}, qed_done, tbl[i].exp_done);
            chk({tag, "_check"}, qed_check, tbl[i].exp_check);
            chk({tag, "_match"}, dup_match, tbl[i].exp_match);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 0, 1, 16'h1234, 16'h1234, 0, 1, 2'b11};
        tbl[1] = '{1, 1, 1, 16'hAAAA, 16'h1234, 0, 1, 2'b00};
        tbl[2] = '{1, 1, 1, 16'hBBBB, 16'h1234, 0, 1, 2'b01};
        tbl[3] = '{0, 1, 0, 16'h0000, 16'h0000, 1, 1, 2'b11};

        do_reset();
        run_table("basic");

        // Second duplicate corrupted on the read side.
        do_reset();
        corrupt_at = 2;
        cyc(1, 1, 0, 1, 0, 16'h1234);
        cyc(1, 1, 1, 1, 0, 16'hAAAA);
        cyc(1, 1, 1, 1, 0, 16'hBBBB);
        cyc(1, 0, 1, 0, 0, 16'h0000);
        chk("corrupt_done", qed_done, 1'b1);
        chk("corrupt_check", qed_check, 1'b0);
        chk("corrupt_match", dup_match, 2'b01);

        // Ordinary writes between the original and its duplicates.
        do_reset();
        cyc(1, 1, 0, 1, 0, 16'h1234);
        cyc(1, 1, 1, 0, 0, 16'h0001);
        cyc(1, 1, 1, 0, 0, 16'h0002);
        cyc(1, 1, 1, 1, 0, 16'hAAAA);
        chk("ilv_dup0", last_dout, 16'h1234);
        cyc(1, 1, 1, 1, 0, 16'hBBBB);
        chk("ilv_dup1", last_dout, 16'h1234);
        for (int i = 0; i < 10 && !qed_done; i++) cyc(1, 0, 1, 0, 0, 16'h0000);
        chk("ilv_done", qed_done, 1'b1);
        chk("ilv_check", qed_check, 1'b1);
        chk("ilv_match", dup_match, 2'b11);

        // Reads withheld: timeout five cycles after entering WAIT.
        do_reset();
        cyc(1, 1, 0, 1, 0, 16'h1234);
        cyc(1, 1, 0, 1, 0, 16'h1111);
        cyc(1, 1, 0, 1, 0, 16'h2222);
        begin
            int n = 0;
            for (int i = 0; i < 20 && !qed_timeout; i++) begin
                cyc(1, 0, 0, 0, 0, 16'h0000);
                n++;
            end
            chk("tmo_cycles", n, 5);
        end
        chk("tmo_flag", qed_timeout, 1'b1);
        chk("tmo_check", qed_check, 1'b0);
        chk("tmo_done", qed_done, 1'b1);
        do_reset();

        // Flush in DUP aborts the run; a fresh run then passes.
        cyc(1, 1, 0, 1, 0, 16'h4321);
        cyc(1, 1, 0, 1, 0, 16'h9999);
        cyc(1, 0, 0, 0, 1, 16'h0000);
        chk("flush_done", qed_done, 1'b0);
        run_table("postflush");

        // Reset in WAIT, then a full core blocks the original.
        do_reset();
        cyc(1, 1, 0, 1, 0, 16'h1234);
        cyc(1, 1, 0, 1, 0, 16'h1111);
        cyc(1, 1, 0, 1, 0, 16'h2222);
        do_reset();
        force_full = 1;
        cyc(1, 1, 0, 1, 0, 16'h5555);
        force_full = 0;
        cyc(1, 1, 0, 1, 0, 16'h6666);
        chk("full_orig", last_dout, 16'h6666);
        cyc(1, 1, 1, 1, 0, 16'h7777);
        chk("full_dup", last_dout, 16'h6666);

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 20; ep++) begin
            do_reset();
            corrupt_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            for (int c = 0; c < 150; c++) begin
                force_full = ($urandom_range(0, 19) == 0);
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 39) == 0, DW'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
